spram_arbiter: RTL and testbench

Two-master request arbiter that sits directly upstream of the single-port `spram` and shares one memory port between two requesters, e.g. instruction fetch (master 0) and load/store (master 1). It grants at most one request per cycle with round-robin fairness, forwards the granted request to the memory port, and tracks ownership of in-flight accesses. Each memory response is routed back to the master that issued the request. It assumes the memory accepts a request every cycle and answers after a fixed latency of `MEM_LATENCY` cycles (0 or 1), with a response for both reads and writes.

---
 rtl/spram_arbiter.sv | 112 +++++++++++
 tb/tb_spram_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/spram_arbiter.sv
// Round-robin arbiter sharing one single-port memory between two masters; zero-cycle grant path,
// responses routed back to the issuing master after MEM_LATENCY (0 or 1) cycles.
module spram_arbiter #(
    parameter int SIZE        = 1024,
    parameter int DATAW       = 32,
    parameter int MEM_LATENCY = 1,
    parameter int ADDRW       = $clog2(SIZE),
    parameter int MASKW       = DATAW / 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [ADDRW-1:0] m0_addr_i,
    input  logic [DATAW-1:0] m0_data_i,
    input  logic [MASKW-1:0] m0_mask_i,
    input  logic             m0_we_i,
    input  logic             m0_valid_i,
    output logic             m0_ready_o,
    output logic [DATAW-1:0] m0_data_o,
    output logic             m0_resp_o,
    input  logic [ADDRW-1:0] m1_addr_i,
    input  logic [DATAW-1:0] m1_data_i,
    input  logic [MASKW-1:0] m1_mask_i,
    input  logic             m1_we_i,
    input  logic             m1_valid_i,
    output logic             m1_ready_o,
    output logic [DATAW-1:0] m1_data_o,
    output logic             m1_resp_o,
    output logic [ADDRW-1:0] mem_addr_o,
    output logic [DATAW-1:0] mem_data_o,
    output logic [MASKW-1:0] mem_mask_o,
    output logic             mem_we_o,
    output logic             mem_valid_o,
    input  logic [DATAW-1:0] mem_data_i,
    input  logic             mem_resp_i
);

    logic grant;
    logic any_vld;
    logic last_q, last_d;
    logic own_vld;
    logic own_id;

    always_comb begin
        if (m0_valid_i && m1_valid_i) begin
            grant = !last_q;
        end else begin
            grant = m1_valid_i;
        end
    end

    // Every valid cycle outside reset is a transfer: the granted master is always accepted.
    assign any_vld     = (m0_valid_i || m1_valid_i) && !rst_i;
    assign mem_valid_o = any_vld;
    assign m0_ready_o  = any_vld && !grant && m0_valid_i;
    assign m1_ready_o  = any_vld &&  grant && m1_valid_i;

    always_comb begin
        mem_addr_o = m0_addr_i;
        mem_data_o = m0_data_i;
        mem_mask_o = m0_mask_i;
        mem_we_o   = any_vld && m0_we_i;
        if (grant) begin
            mem_addr_o = m1_addr_i;
            mem_data_o = m1_data_i;
            mem_mask_o = m1_mask_i;
            mem_we_o   = any_vld && m1_we_i;
        end
    end

    assign last_d = any_vld ? grant : last_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    generate
        if (MEM_LATENCY == 1) begin : g_own_reg
            logic own_vld_q, own_vld_d;
            logic own_id_q, own_id_d;

            assign own_vld_d = any_vld;
            assign own_id_d  = grant;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    own_vld_q <= 1'b0;
                    own_id_q  <= 1'b0;
                end else begin
                    own_vld_q <= own_vld_d;
                    own_id_q  <= own_id_d;
                end
            end

            assign own_vld = own_vld_q;
            assign own_id  = own_id_q;
        end else begin : g_own_comb
            assign own_vld = any_vld;
            assign own_id  = grant;
        end
    endgenerate

    // Gating with rst_i drops the response of an access that was in flight when reset hit.
    assign m0_resp_o = mem_resp_i && own_vld && !own_id && !rst_i;
    assign m1_resp_o = mem_resp_i && own_vld &&  own_id && !rst_i;
    assign m0_data_o = mem_data_i;
    assign m1_data_o = mem_data_i;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench: instance a uses a registered-read memory model (MEM_LATENCY=1),
// instance b a combinational-read model (MEM_LATENCY=0); both share the master inputs.
module tb_spram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  m0_addr, m1_addr;
    logic [31:0] m0_data, m1_data;
    logic [3:0]  m0_mask, m1_mask;
    logic        m0_we, m1_we, m0_valid, m1_valid;

    logic        a_m0_ready, a_m1_ready, a_m0_resp, a_m1_resp;
    logic [31:0] a_m0_rdata, a_m1_rdata;
    logic [9:0]  a_maddr;
    logic [31:0] a_mdata, a_mrdata;
    logic [3:0]  a_mmask;
    logic        a_mwe, a_mvalid, a_mresp;

    logic        b_m0_ready, b_m1_ready, b_m0_resp, b_m1_resp;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic [9:0]  b_maddr;
    logic [31:0] b_mdata, b_mrdata;
    logic [3:0]  b_mmask;
    logic        b_mwe, b_mvalid, b_mresp;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spram_arbiter #(.MEM_LATENCY(1)) u_a (
        .clk_i(clk), .rst_i(rst),
        .m0_addr_i(m0_addr), .m0_data_i(m0_data), .m0_mask_i(m0_mask), .m0_we_i(m0_we),
        .m0_valid_i(m0_valid), .m0_ready_o(a_m0_ready), .m0_data_o(a_m0_rdata), .m0_resp_o(a_m0_resp),
        .m1_addr_i(m1_addr), .m1_data_i(m1_data), .m1_mask_i(m1_mask), .m1_we_i(m1_we),
        .m1_valid_i(m1_valid), .m1_ready_o(a_m1_ready), .m1_data_o(a_m1_rdata), .m1_resp_o(a_m1_resp),
        .mem_addr_o(a_maddr), .mem_data_o(a_mdata), .mem_mask_o(a_mmask), .mem_we_o(a_mwe),
        .mem_valid_o(a_mvalid), .mem_data_i(a_mrdata), .mem_resp_i(a_mresp)
    );

    spram_arbiter #(.MEM_LATENCY(0)) u_b (
        .clk_i(clk), .rst_i(rst),
        .m0_addr_i(m0_addr), .m0_data_i(m0_data), .m0_mask_i(m0_mask), .m0_we_i(m0_we),
        .m0_valid_i(m0_valid), .m0_ready_o(b_m0_ready), .m0_data_o(b_m0_rdata), .m0_resp_o(b_m0_resp),
        .m1_addr_i(m1_addr), .m1_data_i(m1_data), .m1_mask_i(m1_mask), .m1_we_i(m1_we),
        .m1_valid_i(m1_valid), .m1_ready_o(b_m1_ready), .m1_data_o(b_m1_rdata), .m1_resp_o(b_m1_resp),
        .mem_addr_o(b_maddr), .mem_data_o(b_mdata), .mem_mask_o(b_mmask), .mem_we_o(b_mwe),
        .mem_valid_o(b_mvalid), .mem_data_i(b_mrdata), .mem_resp_i(b_mresp)
    );

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'hA0A0_A0A0;
            1:       return 32'hB1B1_B1B1;
            2:       return 32'hAABB_CCDD;
            3:       return 32'h0C0C_0C0C;
            4:       return 32'hDEAD_BEEF;
            default: return 32'h0;
        endcase
    endfunction

    // Registered-read memory: answers every request (read or write) one cycle later.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i);
            a_mresp  <= 1'b0;
            a_mrdata <= 32'h0;
        end else begin
            a_mresp <= a_mvalid;
            if (a_mvalid) begin
                a_mrdata <= mem_a[a_maddr[9:2]];
                if (a_mwe) begin
                    for (int b = 0; b < 4; b++)
                        if (a_mmask[b]) mem_a[a_maddr[9:2]][8*b +: 8] <= a_mdata[8*b +: 8];
                end
            end
        end
    end

    // Combinational-read memory for the zero-latency instance.
    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 256; j++) mem_b[j] <= init_word(j);
        end else if (b_mvalid && b_mwe) begin
            for (int c = 0; c < 4; c++)
                if (b_mmask[c]) mem_b[b_maddr[9:2]][8*c +: 8] <= b_mdata[8*c +: 8];
        end
    end
    assign b_mrdata = mem_b[b_maddr[9:2]];
    assign b_mresp  = b_mvalid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    task automatic drive(input logic v0, input logic [9:0] a0, input logic v1, input logic [9:0] a1);
        m0_valid = v0; m0_addr = a0; m0_we = 1'b0;
        m1_valid = v1; m1_addr = a1; m1_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m0_data = 32'h0; m1_data = 32'h0; m0_mask = 4'h0; m1_mask = 4'h0;
        drive(1'b1, 10'h0, 1'b1, 10'h4);

        // Reset: outputs quiet even with both masters requesting
        next(); look();
        chk("rst_m0_ready", a_m0_ready, 1'b0);
        chk("rst_m1_ready", a_m1_ready, 1'b0);
        chk("rst_mem_valid", a_mvalid, 1'b0);
        chk("rst_resp", {a_m0_resp, a_m1_resp}, 2'b00);
        chk("rst_b_mem_valid", b_mvalid, 1'b0);

        // Contention from reset: grants 0,1,0,1
        next(); rst = 1'b0; look();
        chk("c1_ready", {a_m0_ready, a_m1_ready}, 2'b10);
        chk("c1_addr", a_maddr, 10'h0);
        chk("c1_resp", {a_m0_resp, a_m1_resp}, 2'b00);
        next(); look();
        chk("c2_ready", {a_m0_ready, a_m1_ready}, 2'b01);
        chk("c2_addr", a_maddr, 10'h4);
        chk("c2_resp", {a_m0_resp, a_m1_resp}, 2'b10);
        chk("c2_data", a_m0_rdata, 32'hA0A0_A0A0);
        next(); look();
        chk("c3_ready", {a_m0_ready, a_m1_ready}, 2'b10);
        chk("c3_resp", {a_m0_resp, a_m1_resp}, 2'b01);
        chk("c3_data", a_m1_rdata, 32'hB1B1_B1B1);
        next(); look();
        chk("c4_ready", {a_m0_ready, a_m1_ready}, 2'b01);
        chk("c4_resp", {a_m0_resp, a_m1_resp}, 2'b10);
        chk("c4_data", a_m0_rdata, 32'hA0A0_A0A0);
        next(); drive(1'b0, 10'h0, 1'b0, 10'h0); look();
        chk("c5_mem_valid", a_mvalid, 1'b0);
        chk("c5_mem_we", a_mwe, 1'b0);
        chk("c5_resp", {a_m0_resp, a_m1_resp}, 2'b01);
        chk("c5_data", a_m1_rdata, 32'hB1B1_B1B1);

        // Single master read of 0x10
        next(); drive(1'b1, 10'h10, 1'b0, 10'h0); look();
        chk("s1_ready", {a_m0_ready, a_m1_ready}, 2'b10);
        chk("s1_resp", {a_m0_resp, a_m1_resp}, 2'b00);
        next(); drive(1'b0, 10'h0, 1'b0, 10'h0); look();
        chk("s2_resp", {a_m0_resp, a_m1_resp}, 2'b10);
        chk("s2_data", a_m0_rdata, 32'hDEAD_BEEF);

        // m1 byte-masked write to 0x8
        next(); drive(1'b0, 10'h0, 1'b1, 10'h8);
        m1_we = 1'b1; m1_data = 32'h1122_3344; m1_mask = 4'b0101; look();
        chk("w1_ready", {a_m0_ready, a_m1_ready}, 2'b01);
        chk("w1_mem_we", a_mwe, 1'b1);
        chk("w1_mem_mask", a_mmask, 4'b0101);
        chk("w1_mem_data", a_mdata, 32'h1122_3344);
        next(); drive(1'b0, 10'h0, 1'b0, 10'h0); look();
        chk("w2_resp", {a_m0_resp, a_m1_resp}, 2'b01);
        next(); look();
        chk("idle_resp", {a_m0_resp, a_m1_resp}, 2'b00);

        // Stall: m0 wins (last=1 preserved across idle), m1 holds its read of 0x8
        next(); drive(1'b1, 10'h10, 1'b1, 10'h8); look();
        chk("st1_ready", {a_m0_ready, a_m1_ready}, 2'b10);
        chk("st1_addr", a_maddr, 10'h10);
        next(); drive(1'b0, 10'h0, 1'b1, 10'h8); look();
        chk("st2_ready", {a_m0_ready, a_m1_ready}, 2'b01);
        chk("st2_addr", a_maddr, 10'h8);
        chk("st2_resp", {a_m0_resp, a_m1_resp}, 2'b10);
        chk("st2_data", a_m0_rdata, 32'hDEAD_BEEF);
        next(); drive(1'b0, 10'h0, 1'b0, 10'h0); look();
        chk("st3_resp", {a_m0_resp, a_m1_resp}, 2'b01);
        chk("st3_data", a_m1_rdata, 32'hAA22_CC44);

        // Reset while m0 read is in flight
        next(); drive(1'b1, 10'h0, 1'b0, 10'h0); look();
        chk("r1_ready", {a_m0_ready, a_m1_ready}, 2'b10);
        next(); rst = 1'b1; drive(1'b0, 10'h0, 1'b0, 10'h0); look();
        chk("r2_resp", {a_m0_resp, a_m1_resp}, 2'b00);
        next(); drive(1'b1, 10'h0, 1'b1, 10'h4); look();
        chk("r3_ready", {a_m0_ready, a_m1_ready}, 2'b00);
        next(); rst = 1'b0; look();
        chk("r4_ready", {a_m0_ready, a_m1_ready}, 2'b10);
        chk("r4_resp", {a_m0_resp, a_m1_resp}, 2'b00);

        // Zero-latency instance: m1 reads 0xC, response in the same cycle
        next(); drive(1'b0, 10'h0, 1'b1, 10'hC); look();
        chk("z_ready", {b_m0_ready, b_m1_ready}, 2'b01);
        chk("z_resp", {b_m0_resp, b_m1_resp}, 2'b01);
        chk("z_data", b_m1_rdata, 32'h0C0C_0C0C);
        chk("z_a_resp", {a_m0_resp, a_m1_resp}, 2'b10);
        next(); drive(1'b0, 10'h0, 1'b0, 10'h0); look();
        chk("z_idle_resp", {b_m0_resp, b_m1_resp}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
